// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding and Booth recoding of the {Q[0], Q_1} pair.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth decode of {Q[0], Q_1}: 01 adds M, 10 subtracts M, 00/11 keep A.
    localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
    localparam logic [1:0] BOOTH_ADD    = 2'b01;
    localparam logic [1:0] BOOTH_SUB    = 2'b10;
    localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

endpackage

// File: rtl/seq_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of the {A, Q, Q_1} chain by one bit.
module booth_step
    import seq_mult_pkg::*;
#(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic         q_1,
    input  logic [N-1:0] m,
    output logic [N-1:0] a_out,
    output logic [N-1:0] q_out,
    output logic         q_1_out
);

    logic [N-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            BOOTH_ADD: sum = a + m;
            BOOTH_SUB: sum = a - m;
            default:   sum = a;
        endcase
        a_out   = {sum[N-1], sum[N-1:1]};
        q_out   = {sum[0], q[N-1:1]};
        q_1_out = q[0];
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential WIDTH x WIDTH multiplier (signed or unsigned) using WIDTH+1
// radix-2 Booth steps on operands extended to WIDTH+1 bits.
//
// Handshake: start is sampled only in IDLE or DONE; the operation runs
// while busy=1 and done pulses for exactly one cycle with hi/lo valid.
// hi/lo keep the last completed product until the next one finishes.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] mc,
    input  logic [WIDTH-1:0] mp,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   acc;
    logic [N-1:0]   mq;
    logic           q_1;
    logic [N-1:0]   mr;

    logic [N-1:0]   acc_nx;
    logic [N-1:0]   mq_nx;
    logic           q_1_nx;
    logic [N-1:0]   mc_ext;
    logic [N-1:0]   mp_ext;
    logic           prod_unused;

    // The extra top bit makes unsigned operands look like positive signed ones.
    assign mc_ext = {is_signed & mc[WIDTH-1], mc};
    assign mp_ext = {is_signed & mp[WIDTH-1], mp};

    // The two upper product bits are pure sign extension and never reach hi.
    assign prod_unused = ^acc_nx[WIDTH:WIDTH-1];

    assign state_dbg = state;

    booth_step #(
        .N(N)
    ) u_step (
        .a       (acc),
        .q       (mq),
        .q_1     (q_1),
        .m       (mr),
        .a_out   (acc_nx),
        .q_out   (mq_nx),
        .q_1_out (q_1_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            q_1   <= 1'b0;
            mr    <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mr    <= mc_ext;
                        mq    <= mp_ext;
                        acc   <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    mq  <= mq_nx;
                    q_1 <= q_1_nx;
                    cnt <= cnt + 1'b1;
                    // Result is taken straight from the last step's output.
                    if (cnt == LAST_STEP) begin
                        hi    <= {acc_nx[WIDTH-2:0], mq_nx[WIDTH]};
                        lo    <= mq_nx[WIDTH-1:0];
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult (WIDTH=32): spec vectors, back-to-back start,
// ignored mid-run start, reset abandonment, and scoreboarded products.
module tb_seq_mult;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] mc;
    logic [W-1:0] mp;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] prev_prod;
    logic [2*W-1:0] pend_prod;

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mult #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .mc        (mc),
        .mp        (mp),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // driver tasks: entered and left at 1 ns after a rising edge
    task automatic do_start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        is_signed = sgn;
        mc        = a;
        mp        = b;
        start     = 1'b1;
        pend_prod = model(sgn, a, b);
        exp_q.push_back(pend_prod);
        @(posedge clk);
        #1;
        e0        = cyc;
        start     = 1'b0;
        mc        = $urandom;
        mp        = $urandom;
        is_signed = ~sgn;
    endtask

    task automatic wait_done(input string tag);
        int busy_n;
        int k0;
        k0     = cyc - e0;
        busy_n = busy ? 1 : 0;
        check({tag, " hold"}, {hi, lo}, prev_prod);
        while (done !== 1'b1 && (cyc - e0) < 40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1) begin
                if (busy === 1'b1) busy_n++;
                check({tag, " hold"}, {hi, lo}, prev_prod);
            end
        end
        check({tag, " latency"}, cyc - e0, W + 1);
        check({tag, " busy cycles"}, busy_n, W + 1 - k0);
        check({tag, " busy at done"}, busy, 0);
        prev_prod = pend_prod;
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, done, 0);
        check({tag, " idle state"}, state_dbg, 0);
        check({tag, " result held"}, {hi, lo}, prev_prod);
    endtask

    // scoreboard: every done pulse consumes one expected product
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL scoreboard: observed done with %0d queued expected 1+", exp_q.size());
            end
            if (exp_q.size() != 0) check("scoreboard", {hi, lo}, exp_q.pop_front());
        end
    end

    logic [W-1:0] tbl_a [6];
    logic [W-1:0] tbl_b [6];
    logic         tbl_s [6];

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        mc        = '0;
        mp        = '0;
        prev_prod = '0;
        pend_prod = '0;

        #12;
        check("reset hi/lo", {hi, lo}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset state", state_dbg, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // -3 * 7 signed
        do_start(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_done("neg3x7");
        check("neg3x7 result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        after_done("neg3x7");

        // all ones, unsigned then signed
        do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("ones_u");
        check("ones_u result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        after_done("ones_u");
        do_start(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("ones_s");
        check("ones_s result", {hi, lo}, 64'h0000_0000_0000_0001);
        after_done("ones_s");

        // most negative squared
        do_start(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done("minsq");
        check("minsq result", {hi, lo}, 64'h4000_0000_0000_0000);
        after_done("minsq");

        // 6*7 with a second start at E0+10 that must be ignored
        do_start(1'b1, 32'd6, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        is_signed = 1'b1;
        mc        = 32'd2;
        mp        = 32'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored start busy", busy, 1);
        check("ignored start state", state_dbg, 1);
        wait_done("6x7");
        check("6x7 result", {hi, lo}, 64'h2A);

        // back-to-back start in the DONE cycle
        check("b2b done seen", done, 1);
        do_start(1'b1, 32'd5, 32'd3);
        check("b2b busy", busy, 1);
        check("b2b done cleared", done, 0);
        wait_done("5x3");
        check("5x3 result", {hi, lo}, 64'h0F);
        after_done("5x3");

        // reset at E0+15 abandons the operation
        do_start(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async reset hi/lo", {hi, lo}, 0);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        check("async reset state", state_dbg, 0);
        void'(exp_q.pop_back());
        prev_prod = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post reset idle", state_dbg, 0);
        do_start(1'b0, 32'd1, 32'd1);
        wait_done("1x1");
        check("1x1 result", {hi, lo}, 64'h1);
        after_done("1x1");

        // boundary and random operands, alternating back-to-back
        tbl_a = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, $urandom, $urandom, $urandom};
        tbl_b = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, $urandom, $urandom, $urandom};
        tbl_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1))};
        for (int i = 0; i < 6; i++) begin
            do_start(tbl_s[i], tbl_a[i], tbl_b[i]);
            wait_done("table");
            if (i % 2 == 1) after_done("table");
        end
        check("minxmax signed", model(1'b1, 32'h7FFF_FFFF, 32'h8000_0000), 64'hC000_0000_8000_0000);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 mc  input  WIDTH  multiplicand; sampled with start.
REQ-007 mp  input  WIDTH  multiplier; sampled with start.
REQ-008 hi  output  WIDTH  upper half of last completed product.
REQ-009 lo  output  WIDTH  lower half of last completed product.
REQ-010 busy  output  1  high while an operation is in RUN.
REQ-011 done  output  1  single-cycle pulse, result valid on hi/lo.

Function
REQ-012 FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE/DONE with start=1 -> RUN at that edge (E0); operands latched, extended to WIDTH+1 bits (sign-extended if is_signed, else zero-extended); accumulator cleared, Q_1 cleared, iteration counter cleared.
REQ-014 DONE with start=0 -> IDLE; IDLE with start=0 -> IDLE.
REQ-015 RUN SHALL perform one radix-2 Booth step per edge on (WIDTH+1)-bit accumulator/multiplier: {Q[0],Q_1}=01 add M, 10 subtract M, else no-op; then arithmetic right shift of {A,Q,Q_1}.
REQ-016 RUN SHALL execute exactly WIDTH+1 steps (E1..E0+WIDTH+1), independent of is_signed and operand values.
REQ-017 At the final step edge the low 2*WIDTH bits of the product SHALL be written to the hi/lo result registers and state -> DONE.
REQ-018 hi/lo SHALL hold the previous result throughout RUN and change only at the REQ-017 edge.
REQ-019 busy SHALL be 1 exactly in RUN (edges E0 through E0+WIDTH+1 exclusive of DONE); done SHALL be 1 exactly in DONE.
REQ-020 Latency: done high in the cycle beginning at E0+WIDTH+1 (33 cycles after start edge for WIDTH=32).
REQ-021 start while in RUN SHALL be ignored; operands and mode SHALL not change mid-operation.
REQ-022 start in DONE SHALL begin a new operation at that edge (back-to-back, no idle cycle); done still pulses that cycle.
REQ-023 Signed result SHALL equal the exact 2*WIDTH-bit two's-complement product; unsigned result the exact 2*WIDTH-bit unsigned product; no overflow flag.
REQ-024 Iteration counter width SHALL be clog2(WIDTH+2); no wrap-around permitted within an operation.

Reset
REQ-025 reset=0 SHALL immediately, asynchronously force IDLE, hi=0, lo=0, busy=0, done=0, and clear all datapath registers and counter.
REQ-026 Reset during RUN SHALL abandon the operation; no partial result SHALL appear on hi/lo.
REQ-027 After reset release, first start is accepted at the first rising edge with start=1.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the Booth-decode constants.
REQ-029 One combinational sub-module booth_step SHALL implement add/subtract/shift of one iteration, parametrised by WIDTH+1.
REQ-030 Top-level SHALL contain FSM, counter, operand/accumulator registers, and result registers.

Verification (WIDTH=32)
REQ-031 is_signed=1, mc=0xFFFFFFFD (-3), mp=0x00000007 -> done at E0+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 is_signed=0, mc=mp=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same operands signed -> hi=0x00000000, lo=0x00000001.
REQ-033 is_signed=1, mc=mp=0x80000000 -> hi=0x40000000, lo=0x00000000; busy high 33 cycles, done high 1 cycle.
REQ-034 Start 6*7 signed, pulse start again at E0+10 with 2*2 -> second start ignored, result hi=0, lo=0x2A; hi/lo unchanged from prior values until done.
REQ-035 Start in DONE cycle with mc=5, mp=3 immediately after 6*7 -> done pulses, new RUN begins same edge, next result lo=0x0F 33 cycles later.
REQ-036 Assert reset at E0+15 of an operation -> hi, lo, busy, done 0 immediately; after release, start 1*1 yields lo=1 at E0+33.
